binarize_tile_sched: RTL and testbench

- Sequences the combinational 3x3 local-threshold binarizer (72-bit tile in, 72-bit tile out) over a frame of tiles.
- Collects a stream of 8-bit pixels into a 9-pixel tile, then presents it to the binarizer on `dp_tile`.
- Waits a fixed settle time, captures the result and compresses it to a 9-bit mask.
- Emits masks with a valid/ready handshake; sits between the pixel source and the text-mask packer.

---
 rtl/binarize_pkg.sv | 24 ++
 rtl/binarize_tile_sched_if.sv | 22 ++
 rtl/binarize_tile_sched_loader.sv | 40 ++++
 rtl/binarize_tile_sched.sv | 123 ++++++++++++
 tb/tb_binarize_tile_sched.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/binarize_pkg.sv
// Shared types and helpers for the binarizer tile scheduler.
package binarize_pkg;

  localparam int PIX_W     = 8;
  localparam int TILE_PIX  = 9;
  localparam int TILE_BITS = PIX_W * TILE_PIX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WAIT = 2'd2,
    EMIT = 2'd3
  } state_e;

  // Bit k of the result is the LSB of byte k.
  // Byte k holds pixel 8-k, so bit 8 corresponds to pixel 0.
  function automatic logic [TILE_PIX-1:0] byte_lsbs(input logic [TILE_BITS-1:0] w);
    logic [TILE_PIX-1:0] m;
    m = '0;
    for (int k = 0; k < TILE_PIX; k++) m[k] = w[PIX_W*k];
    return m;
  endfunction

endpackage

// File: rtl/binarize_tile_sched_if.sv
// Pixel-in and mask-out valid/ready streams of the binarizer tile scheduler.
interface binarize_tile_sched_if;
  import binarize_pkg::*;

  logic [PIX_W-1:0]    pix_in;
  logic                pix_valid;
  logic                pix_ready;
  logic [TILE_PIX-1:0] mask_out;
  logic                mask_valid;
  logic                mask_ready;
  logic                mask_last;

  modport master (
    output pix_in, pix_valid, mask_ready,
    input  pix_ready, mask_out, mask_valid, mask_last
  );

  modport slave (
    input  pix_in, pix_valid, mask_ready,
    output pix_ready, mask_out, mask_valid, mask_last
  );
endinterface

// File: rtl/binarize_tile_sched_loader.sv
// Tile loader: shifts pixels into a 72-bit tile from the LSB and counts them.
module tile_loader
  import binarize_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 load_en,
  input  logic [PIX_W-1:0]     pix_in,
  output logic [TILE_BITS-1:0] tile,
  output logic                 full
);

  logic [TILE_BITS-1:0] tile_q, tile_d;
  logic [3:0]           cnt_q, cnt_d;

  assign full = (cnt_q == 4'(TILE_PIX - 1));
  assign tile = tile_q;

  always_comb begin
    tile_d = tile_q;
    cnt_d  = cnt_q;
    if (load_en) begin
      tile_d = {tile_q[TILE_BITS-PIX_W-1:0], pix_in};
      cnt_d  = full ? 4'd0 : cnt_q + 4'd1;
    end
    if (clr) cnt_d = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_q <= '0;
      cnt_q  <= '0;
    end else begin
      tile_q <= tile_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/binarize_tile_sched.sv
// Sequences the 3x3 binarizer over a frame of tiles and emits 9-bit masks.
// Optional BINARIZE_DARK_COUNT_EN adds a per-frame dark-pixel counter.
//
// state | meaning
// IDLE  | waiting for frame_start
// FILL  | accepting pixels into the tile
// WAIT  | tile held on dp_tile while the binarizer settles
// EMIT  | mask offered to the consumer
module binarize_tile_sched
  import binarize_pkg::*;
#(
  parameter int SETTLE          = 2,
  parameter int TILES_PER_FRAME = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  binarize_tile_sched_if.slave  bus,
  output logic [TILE_BITS-1:0]  dp_tile,
  input  logic [TILE_BITS-1:0]  dp_result,
  output logic                  busy,
  output logic                  frame_done
`ifdef BINARIZE_DARK_COUNT_EN
  , output logic [15:0]         dark_count
`endif
);

  state_e              state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [15:0]         tile_cnt_q, tile_cnt_d;
  logic [TILE_PIX-1:0] mask_q, mask_d;
  logic                frame_done_q, frame_done_d;
  logic                full, pix_hs, mask_hs, is_last, settled, start;

  // Only the byte LSBs carry information; the rest is deliberately ignored.
  logic dp_result_unused;
  assign dp_result_unused = ^dp_result;

  assign start   = (state_q == IDLE) && frame_start;
  assign pix_hs  = (state_q == FILL) && bus.pix_valid;
  assign mask_hs = (state_q == EMIT) && bus.mask_ready;
  assign is_last = (tile_cnt_q == 16'(TILES_PER_FRAME - 1));
  assign settled = (wait_cnt_q == 4'(SETTLE - 1));

  tile_loader u_loader (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .load_en (pix_hs),
    .pix_in  (bus.pix_in),
    .tile    (dp_tile),
    .full    (full)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start)     state_d = FILL;
      FILL:    if (pix_hs && full)  state_d = WAIT;
      WAIT:    if (settled)         state_d = EMIT;
      EMIT:    if (mask_hs)         state_d = is_last ? IDLE : FILL;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.pix_ready  = (state_q == FILL);
    bus.mask_valid = (state_q == EMIT);
    bus.mask_last  = (state_q == EMIT) && is_last;
    bus.mask_out   = mask_q;
    busy           = (state_q != IDLE);
    frame_done     = frame_done_q;
  end

  always_comb begin
    wait_cnt_d   = (state_q == WAIT) ? wait_cnt_q + 4'd1 : 4'd0;
    tile_cnt_d   = tile_cnt_q;
    mask_d       = mask_q;
    frame_done_d = mask_hs && is_last;
    if (start)                tile_cnt_d = 16'd0;
    if (mask_hs && !is_last)  tile_cnt_d = tile_cnt_q + 16'd1;
    if ((state_q == WAIT) && settled) mask_d = byte_lsbs(dp_result);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q   <= '0;
      tile_cnt_q   <= '0;
      mask_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      tile_cnt_q   <= tile_cnt_d;
      mask_q       <= mask_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef BINARIZE_DARK_COUNT_EN
  logic [15:0] dark_q, dark_d;
  logic [16:0] dark_sum;

  assign dark_sum   = {1'b0, dark_q} + 17'(TILE_PIX - $countones(mask_q));
  assign dark_count = dark_q;

  always_comb begin
    dark_d = dark_q;
    if (start)        dark_d = 16'd0;
    else if (mask_hs) dark_d = dark_sum[16] ? 16'hFFFF : dark_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) dark_q <= '0;
    else     dark_q <= dark_d;
  end
`endif

endmodule

// File: tb/tb_binarize_tile_sched.sv
// Directed bench for binarize_tile_sched with a 2-tile frame and SETTLE=2.
module tb_binarize_tile_sched;
  import binarize_pkg::*;

  localparam int SETTLE = 2;
  localparam int TPF    = 2;

  logic        clk = 1'b0;
  logic        rst, frame_start, busy, frame_done;
  logic [71:0] dp_tile, dp_result;
`ifdef BINARIZE_DARK_COUNT_EN
  logic [15:0] dark_count;
`endif

  binarize_tile_sched_if bus();

  binarize_tile_sched #(.SETTLE(SETTLE), .TILES_PER_FRAME(TPF)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .bus         (bus),
    .dp_tile     (dp_tile),
    .dp_result   (dp_result),
    .busy        (busy),
    .frame_done  (frame_done)
`ifdef BINARIZE_DARK_COUNT_EN
    , .dark_count (dark_count)
`endif
  );

  always #5 clk = ~clk;

  // Binarizer model: pixel above the tile mean is background (FF), else dark (00).
  logic        ovr_en;
  logic [71:0] ovr_val;

  function automatic logic [71:0] binarize_model(input logic [71:0] t);
    int sum, thr;
    logic [71:0] r;
    sum = 0;
    r   = '0;
    for (int p = 0; p < 9; p++) sum += int'(t[8*p +: 8]);
    thr = sum / 9;
    for (int p = 0; p < 9; p++) r[8*p +: 8] = (int'(t[8*p +: 8]) > thr) ? 8'hFF : 8'h00;
    return r;
  endfunction

  always_comb dp_result = ovr_en ? ovr_val : binarize_model(dp_tile);

  int checks = 0;
  int errors = 0;

  logic [7:0] px_ramp [9];
  logic [7:0] px_alt  [9];

  task automatic feed(input logic [7:0] px [9], input int first, input int last, input bit gaps);
    int i, guard;
    i = first;
    guard = 0;
    while (i < last) begin
      @(negedge clk);
      bus.pix_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.pix_in    = bus.pix_valid ? px[i] : 8'hEE;
      if (bus.pix_valid && bus.pix_ready) i++;
      guard++;
      if (guard > 300) begin
        checks++; errors++;
        $display("FAIL feed_timeout: accepted %0d pixels, required %0d", i, last);
        break;
      end
    end
  endtask

  task automatic wait_mask(output int lat, output logic [71:0] tile_seen);
    lat = 0;
    tile_seen = '0;
    do begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      lat++;
      if (lat == 1) tile_seen = dp_tile;
    end while (!bus.mask_valid && lat < 50);
  endtask

  task automatic mask_hs();
    bus.mask_ready = 1'b1;
    @(negedge clk);
    bus.mask_ready = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_start = 1'b0; ovr_en = 1'b0; ovr_val = '0;
    bus.pix_valid = 1'b0; bus.pix_in = '0; bus.mask_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready: got %b want 0", bus.pix_ready); end
    checks++; if (dp_tile !== 72'h0) begin errors++; $display("FAIL reset_dp_tile: got %h want 0", dp_tile); end
    checks++; if (bus.mask_out !== 9'h0) begin errors++; $display("FAIL reset_mask_out: got %h want 0", bus.mask_out); end
    checks++; if (bus.mask_valid !== 1'b0) begin errors++; $display("FAIL reset_mask_valid: got %b want 0", bus.mask_valid); end
    checks++; if (bus.mask_last !== 1'b0) begin errors++; $display("FAIL reset_mask_last: got %b want 0", bus.mask_last); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
  endtask

  task automatic test_latency_and_stall();
    int lat;
    logic [71:0] t;
    start_frame();
    feed(px_ramp, 0, 9, 1'b0);
    wait_mask(lat, t);
    checks++; if (lat !== 3) begin errors++; $display("FAIL latency: got %0d want 3", lat); end
    checks++; if (t !== 72'h101112131415161718) begin errors++; $display("FAIL ramp_tile: got %h want 101112131415161718", t); end
    checks++; if (bus.mask_out !== 9'h00F) begin errors++; $display("FAIL ramp_mask: got %h want 00f", bus.mask_out); end
    checks++; if (bus.mask_last !== 1'b0) begin errors++; $display("FAIL tile0_last: got %b want 0", bus.mask_last); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.mask_out !== 9'h00F || bus.mask_valid !== 1'b1 || bus.pix_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: mask=%h valid=%b pix_ready=%b want 00f/1/0", k, bus.mask_out, bus.mask_valid, bus.pix_ready);
      end
    end
    mask_hs();
    checks++; if (frame_done !== 1'b0 || bus.pix_ready !== 1'b1) begin
      errors++; $display("FAIL tile0_after_hs: frame_done=%b pix_ready=%b want 0/1", frame_done, bus.pix_ready); end
    ovr_en = 1'b1; ovr_val = 72'h00FF00FF00FF00FF00;
    feed(px_ramp, 0, 9, 1'b0);
    wait_mask(lat, t);
    checks++; if (bus.mask_out !== 9'h0AA) begin errors++; $display("FAIL alt_mask: got %h want 0aa", bus.mask_out); end
    checks++; if (bus.mask_last !== 1'b1) begin errors++; $display("FAIL tile1_last: got %b want 1", bus.mask_last); end
    mask_hs();
    checks++; if (frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL frame_done_pulse: frame_done=%b busy=%b want 1/0", frame_done, busy); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_once: got %b want 0", frame_done); end
    ovr_en = 1'b0;
  endtask

  task automatic test_gaps();
    int lat;
    logic [71:0] t;
    start_frame();
    feed(px_ramp, 0, 4, 1'b1);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    feed(px_ramp, 4, 9, 1'b1);
    wait_mask(lat, t);
    checks++; if (t !== 72'h101112131415161718) begin errors++; $display("FAIL gap_tile: got %h want 101112131415161718", t); end
    checks++; if (bus.mask_out !== 9'h00F || lat !== 3) begin
      errors++; $display("FAIL gap_mask: mask=%h lat=%0d want 00f/3", bus.mask_out, lat); end
    mask_hs();
    feed(px_ramp, 0, 9, 1'b1);
    wait_mask(lat, t);
    checks++; if (t !== 72'h101112131415161718 || bus.mask_last !== 1'b1) begin
      errors++; $display("FAIL gap_tile1: tile=%h last=%b want 101112131415161718/1", t, bus.mask_last); end
    mask_hs();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL gap_frame_done: got %b want 1", frame_done); end
  endtask

  task automatic test_reset_midframe();
    int lat;
    logic [71:0] t;
    logic [7:0] px30 [9];
    for (int i = 0; i < 9; i++) px30[i] = 8'(8'h30 + i);
    start_frame();
    feed(px30, 0, 5, 1'b0);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || bus.pix_ready !== 1'b0 || dp_tile !== 72'h0) begin
      errors++; $display("FAIL midrst_state: busy=%b pix_ready=%b tile=%h want 0/0/0", busy, bus.pix_ready, dp_tile); end
    checks++; if (bus.mask_out !== 9'h0 || bus.mask_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL midrst_outs: mask=%h valid=%b done=%b want 0/0/0", bus.mask_out, bus.mask_valid, frame_done); end
    start_frame();
    feed(px_alt, 0, 9, 1'b0);
    wait_mask(lat, t);
    checks++; if (t !== 72'hF008F008F008F008F0) begin errors++; $display("FAIL midrst_tile: got %h want f008f008f008f008f0", t); end
    checks++; if (bus.mask_out !== 9'h155) begin errors++; $display("FAIL midrst_mask: got %h want 155", bus.mask_out); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [71:0] t;
    start_frame();
    ovr_en = 1'b1; ovr_val = 72'h0;
    feed(px_ramp, 0, 9, 1'b0);
    wait_mask(lat, t);
    checks++; if (bus.mask_out !== 9'h000) begin errors++; $display("FAIL dark_mask0: got %h want 000", bus.mask_out); end
    mask_hs();
    ovr_val = 72'hFFFFFFFFFF00000000;
    feed(px_ramp, 0, 9, 1'b0);
    wait_mask(lat, t);
    checks++; if (bus.mask_out !== 9'h1F0) begin errors++; $display("FAIL dark_mask1: got %h want 1f0", bus.mask_out); end
    mask_hs();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_frame_done: got %b want 1", frame_done); end
`ifdef BINARIZE_DARK_COUNT_EN
    checks++; if (dark_count !== 16'd13) begin errors++; $display("FAIL dark_count: got %0d want 13", dark_count); end
`endif
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checks++; if (busy !== 1'b1 || bus.pix_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_restart: busy=%b pix_ready=%b want 1/1", busy, bus.pix_ready); end
`ifdef BINARIZE_DARK_COUNT_EN
    checks++; if (dark_count !== 16'd0) begin errors++; $display("FAIL dark_clear: got %0d want 0", dark_count); end
`endif
    ovr_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 9; i++) begin
      px_ramp[i] = 8'(8'h10 + i);
      px_alt[i]  = (i % 2 == 0) ? 8'hF0 : 8'h08;
    end
    test_reset();
    test_latency_and_stall();
    test_gaps();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
